hilo_muldiv_unit: RTL and testbench

- Multi-cycle MULT/MULTU/DIV/DIVU engine holding the architectural HI/LO pair.
- Sits beside the register file in the EX stage. Operands come from the register file read ports.
- hi/lo feed the writeback mux for MFHI/MFLO, which drives the register file write data.
- Decode/hazard logic stalls MFHI/MFLO/MTHI/MTLO/new mul-div while busy=1.

---
 rtl/hilo_muldiv_unit.sv | 254 +++++++++++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
//   Multi-cycle MULT/MULTU/DIV/DIVU engine that owns the architectural HI/LO
//   pair. It sits beside the register file in EX. hi/lo feed the MFHI/MFLO
//   writeback mux. Decode stalls dependent instructions while busy=1.
//
//   Ports:
//     clk      rising-edge clock
//     reset    asynchronous active-low reset (clears the block when 0)
//     start    launch an operation (sampled only in IDLE)
//     op       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//     src_a    rs operand (multiplicand / dividend)
//     src_b    rt operand (multiplier / divisor)
//     mthi     write wr_data to HI (IDLE only, loses to start)
//     mtlo     write wr_data to LO (IDLE only, loses to start)
//     wr_data  MTHI/MTLO data
//     cancel   abort the in-flight operation; suppresses start in IDLE
//     busy     operation in flight
//     done     one-cycle pulse after the result commit
//     hi, lo   HI/LO registers
//
//   Parameters:
//     DIVZERO_LO              LO value committed on divide-by-zero
//     DIVZERO_HI_IS_DIVIDEND  1: HI = dividend on divide-by-zero, 0: HI = 0
//
//   Build option:
//     HILO_SINGLE_CYCLE_MUL_EN  When defined, MULT/MULTU use a combinational
//                               64-bit multiply and commit one edge after the
//                               start edge. Division is iterative either way.
//
//   Timing (E0 = start edge): iterative ops commit at E0+33. Divide-by-zero
//   (and multiply with HILO_SINGLE_CYCLE_MUL_EN) commits at E0+1. done is
//   high for the cycle after the commit edge.
module hilo_muldiv_unit #(
  parameter logic [31:0] DIVZERO_LO             = 32'hFFFFFFFF,
  parameter logic        DIVZERO_HI_IS_DIVIDEND = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wr_data,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  logic [1:0]  state;
  logic [4:0]  counter;

  // Shared working registers.
  //   MUL: opnd = multiplicand magnitude, {wk_hi, wk_lo} = partial product
  //        with the multiplier shifting out of wk_lo.
  //   DIV: opnd = divisor magnitude, wk_hi = partial remainder,
  //        wk_lo = dividend shifting out / quotient shifting in.
  //   Divide-by-zero: wk_hi holds the raw dividend for the HI commit.
  logic [31:0] opnd;
  logic [31:0] wk_hi;
  logic [31:0] wk_lo;

  logic        is_div;
  logic        div_zero;
  logic        res_neg;   // product / quotient sign (sa ^ sb)
  logic        rem_neg;   // remainder sign (dividend sign)

  // ---------------------------------------------------------------------------
  // Launch decode: operand signs and magnitudes
  // ---------------------------------------------------------------------------
  logic        is_signed;
  logic        sa;
  logic        sb;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        launch;

  always_comb begin
    is_signed = ~op[0];
    sa        = is_signed & src_a[31];
    sb        = is_signed & src_b[31];
    a_mag     = sa ? (32'd0 - src_a) : src_a;
    b_mag     = sb ? (32'd0 - src_b) : src_b;
  end

  assign launch = (state == S_IDLE) && start && !cancel;
  assign busy   = (state != S_IDLE);

`ifdef HILO_SINGLE_CYCLE_MUL_EN
  // Sign/zero extension to 64 bits makes the low 64 bits of the product
  // correct for both MULT and MULTU.
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] full_prod;

  always_comb begin
    ext_a     = {{32{sa}}, src_a};
    ext_b     = {{32{sb}}, src_b};
    full_prod = ext_a * ext_b;
  end
`endif

  // ---------------------------------------------------------------------------
  // Radix-2 iteration datapaths
  // ---------------------------------------------------------------------------
  // Shift-add multiply: add the multiplicand when the current multiplier bit
  // is set, then shift the 65-bit {carry, hi, lo} right by one.
  logic [32:0] mul_sum;
  assign mul_sum = {1'b0, wk_hi} + {1'b0, (wk_lo[0] ? opnd : 32'd0)};

  // Restoring divide: shift the next dividend bit into the remainder and
  // subtract the divisor if it fits. The remainder is always below the
  // divisor, so the 32-bit difference is exact whenever div_ge is set.
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_diff;

  always_comb begin
    div_shift = {wk_hi, wk_lo[31]};
    div_ge    = (div_shift >= {1'b0, opnd});
    div_diff  = div_shift[31:0] - opnd;
  end

  // ---------------------------------------------------------------------------
  // Commit values (sign correction)
  // ---------------------------------------------------------------------------
  logic [63:0] prod_raw;
  logic [63:0] prod_fix;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

  always_comb begin
    prod_raw = {wk_hi, wk_lo};
    prod_fix = res_neg ? (64'd0 - prod_raw) : prod_raw;
    if (div_zero) begin
      fix_lo = DIVZERO_LO;
      fix_hi = DIVZERO_HI_IS_DIVIDEND ? wk_hi : 32'd0;
    end else if (is_div) begin
      fix_lo = res_neg ? (32'd0 - wk_lo) : wk_lo;
      fix_hi = rem_neg ? (32'd0 - wk_hi) : wk_hi;
    end else begin
      fix_lo = prod_fix[31:0];
      fix_hi = prod_fix[63:32];
    end
  end

  // ---------------------------------------------------------------------------
  // Control and state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      counter  <= '0;
      opnd     <= '0;
      wk_hi    <= '0;
      wk_lo    <= '0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      res_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (launch) begin
            is_div   <= op[1];
            rem_neg  <= sa;
            counter  <= '0;
            div_zero <= 1'b0;
            if (op[1]) begin
              res_neg <= sa ^ sb;
              if (src_b == 32'd0) begin
                // No iterations: straight to commit with the raw dividend.
                div_zero <= 1'b1;
                wk_hi    <= src_a;
                wk_lo    <= '0;
                state    <= S_FIX;
              end else begin
                opnd  <= b_mag;
                wk_hi <= '0;
                wk_lo <= a_mag;
                state <= S_DIV;
              end
            end else begin
`ifdef HILO_SINGLE_CYCLE_MUL_EN
              // Product is already signed; FIX only commits it.
              res_neg <= 1'b0;
              wk_hi   <= full_prod[63:32];
              wk_lo   <= full_prod[31:0];
              state   <= S_FIX;
`else
              res_neg <= sa ^ sb;
              opnd    <= a_mag;
              wk_hi   <= '0;
              wk_lo   <= b_mag;
              state   <= S_MUL;
`endif
            end
          end else begin
            if (mthi) hi <= wr_data;
            if (mtlo) lo <= wr_data;
          end
        end

        S_MUL: begin
          if (cancel) begin
            state <= S_IDLE;
          end else begin
            wk_hi   <= mul_sum[32:1];
            wk_lo   <= {mul_sum[0], wk_lo[31:1]};
            counter <= counter + 5'd1;
            if (counter == 5'd31) state <= S_FIX;
          end
        end

        S_DIV: begin
          if (cancel) begin
            state <= S_IDLE;
          end else begin
            wk_hi   <= div_ge ? div_diff : div_shift[31:0];
            wk_lo   <= {wk_lo[30:0], div_ge};
            counter <= counter + 5'd1;
            if (counter == 5'd31) state <= S_FIX;
          end
        end

        S_FIX: begin
          // A cancel on the commit edge still aborts: no commit, no done.
          if (!cancel) begin
            hi   <= fix_hi;
            lo   <= fix_lo;
            done <= 1'b1;
          end
          counter <= '0;
          state   <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Testbench for hilo_muldiv_unit. Expected results are pushed to a scoreboard
// queue at launch and popped when done pulses.
module tb_hilo_muldiv_unit;

`ifdef HILO_SINGLE_CYCLE_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT  = 33;
  localparam int DZ_LAT   = 1;
  localparam int WAIT_MAX = 80;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wr_data;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  hilo_muldiv_unit #(
    .DIVZERO_LO             (32'hFFFFFFFF),
    .DIVZERO_HI_IS_DIVIDEND (1'b1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .src_a   (src_a),
    .src_b   (src_b),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .wr_data (wr_data),
    .cancel  (cancel),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: {hi, lo} for each op with default parameters.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    logic        sgn, na, nb;
    logic [31:0] am, bm, q, r;
    logic [63:0] p;
    sgn = !o[0];
    na  = sgn && a[31];
    nb  = sgn && b[31];
    am  = na ? 32'd0 - a : a;
    bm  = nb ? 32'd0 - b : b;
    if (!o[1]) begin
      p = {32'd0, am} * {32'd0, bm};
      if (na ^ nb) p = 64'd0 - p;
      return p;
    end
    if (b == 32'd0) return {a, 32'hFFFFFFFF};
    q = am / bm;
    r = am % bm;
    if (na ^ nb) q = 32'd0 - q;
    if (na) r = 32'd0 - r;
    return {r, q};
  endfunction

  function automatic int lat_of(input logic [1:0] o, input logic [31:0] b);
    if (!o[1]) return MUL_LAT;
    if (b == 32'd0) return DZ_LAT;
    return DIV_LAT;
  endfunction

  // Called at a negedge; returns at the negedge after the start edge (E0).
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_res, input int lat, input bit push);
    exp_t e;
    op    = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    if (push) begin
      e.hi  = exp_res[63:32];
      e.lo  = exp_res[31:0];
      e.lat = lat;
      sb_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
  endtask

  // Counts negedges after E0 until done is seen (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < WAIT_MAX) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic pop_exp(output exp_t e);
    if (sb_q.size() == 0) begin
      e.hi = 32'hx; e.lo = 32'hx; e.lat = -1;
    end else begin
      e = sb_q.pop_front();
    end
  endtask

  task automatic mt_write(input logic h, input logic l, input logic [31:0] d);
    mthi    = h;
    mtlo    = l;
    wr_data = d;
    @(posedge clk);
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset;
    int   lat;
    int   seen;
    exp_t e;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++; $display("FAIL reset_hilo: got hi=%h lo=%h, want 0/0", hi, lo);
    end
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got busy=%b done=%b, want 0/0", busy, done);
    end
    reset = 1'b1;
    @(negedge clk);

    // Reset mid-division at cycle 10
    mt_write(1'b1, 1'b1, 32'hA5A5A5A5);
    launch(2'b11, 32'd1000, 32'd3, 64'd0, 0, 1'b0);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_after_start: got %b, want 1", busy);
    end
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_div: got hi=%h lo=%h busy=%b, want 0/0/0", hi, lo, busy);
    end
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL reset_no_done: got %0d done pulses, want 0", seen);
    end

    // First start after release works normally: DIVU 100/7
    launch(2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, DIV_LAT, 1'b1);
    wait_done(lat);
    pop_exp(e);
    n_checks++;
    if (lat != e.lat || hi !== e.hi || lo !== e.lo) begin
      n_fail++;
      $display("FAIL post_reset_divu: got lat=%0d hi=%h lo=%h, want lat=%0d hi=%h lo=%h",
               lat, hi, lo, e.lat, e.hi, e.lo);
    end
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_mthi_mtlo;
    mt_write(1'b1, 1'b1, 32'h12345678);
    n_checks++;
    if (hi !== 32'h12345678 || lo !== 32'h12345678) begin
      n_fail++; $display("FAIL mt_both: got hi=%h lo=%h, want 12345678/12345678", hi, lo);
    end
    mt_write(1'b1, 1'b0, 32'hCAFEBABE);
    n_checks++;
    if (hi !== 32'hCAFEBABE || lo !== 32'h12345678) begin
      n_fail++; $display("FAIL mthi_only: got hi=%h lo=%h, want cafebabe/12345678", hi, lo);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_multu;
    int   lat;
    exp_t e;
    launch(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'hFFFFFFFE, 32'h00000001}, MUL_LAT, 1'b1);
    wait_done(lat);
    pop_exp(e);
    n_checks++;
    if (lat != e.lat || hi !== e.hi || lo !== e.lo) begin
      n_fail++;
      $display("FAIL multu_max: got lat=%0d hi=%h lo=%h, want lat=%0d hi=%h lo=%h",
               lat, hi, lo, e.lat, e.hi, e.lo);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL multu_busy_drop: got busy=%b, want 0", busy);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL multu_done_width: got done=%b on second cycle, want 0", done);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_mult;
    int   lat;
    exp_t e;
    launch(2'b00, 32'hFFFFFFFE, 32'd3, {32'hFFFFFFFF, 32'hFFFFFFFA}, MUL_LAT, 1'b1);
    wait_done(lat);
    pop_exp(e);
    n_checks++;
    if (lat != e.lat || hi !== e.hi || lo !== e.lo) begin
      n_fail++;
      $display("FAIL mult_neg: got lat=%0d hi=%h lo=%h, want lat=%0d hi=%h lo=%h",
               lat, hi, lo, e.lat, e.hi, e.lo);
    end
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_div;
    int   lat;
    exp_t e;
    launch(2'b10, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, DIV_LAT, 1'b1);
    wait_done(lat);
    pop_exp(e);
    n_checks++;
    if (lat != e.lat || hi !== e.hi || lo !== e.lo) begin
      n_fail++;
      $display("FAIL div_neg7_2: got lat=%0d hi=%h lo=%h, want lat=%0d hi=%h lo=%h",
               lat, hi, lo, e.lat, e.hi, e.lo);
    end
    @(negedge clk);

    launch(2'b11, 32'd7, 32'd0, {32'd7, 32'hFFFFFFFF}, DZ_LAT, 1'b1);
    wait_done(lat);
    pop_exp(e);
    n_checks++;
    if (lat != e.lat || hi !== e.hi || lo !== e.lo) begin
      n_fail++;
      $display("FAIL divu_by_zero: got lat=%0d hi=%h lo=%h, want lat=%0d hi=%h lo=%h",
               lat, hi, lo, e.lat, e.hi, e.lo);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL divzero_done_width: got done=%b busy=%b, want 0/0", done, busy);
    end

    launch(2'b10, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, DIV_LAT, 1'b1);
    wait_done(lat);
    pop_exp(e);
    n_checks++;
    if (lat != e.lat || hi !== e.hi || lo !== e.lo) begin
      n_fail++;
      $display("FAIL div_intmin_neg1: got lat=%0d hi=%h lo=%h, want lat=%0d hi=%h lo=%h",
               lat, hi, lo, e.lat, e.hi, e.lo);
    end
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_cancel;
    int   lat;
    int   seen;
    exp_t e;
    mt_write(1'b1, 1'b0, 32'h11111111);
    mt_write(1'b0, 1'b1, 32'h22222222);
    launch(2'b11, 32'd100, 32'd7, 64'd0, 0, 1'b0);
    repeat (19) @(negedge clk);
    cancel = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cancel = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'h11111111 || lo !== 32'h22222222) begin
      n_fail++;
      $display("FAIL cancel_state: got busy=%b hi=%h lo=%h, want 0/11111111/22222222",
               busy, hi, lo);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0 || hi !== 32'h11111111 || lo !== 32'h22222222) begin
      n_fail++; $display("FAIL cancel_no_commit: got %0d done pulses hi=%h lo=%h, want 0", seen, hi, lo);
    end

    // Start while busy is ignored
    launch(2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, DIV_LAT, 1'b1);
    repeat (4) @(negedge clk);
    op    = 2'b01;
    src_a = 32'd3;
    src_b = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    lat += 5;
    pop_exp(e);
    n_checks++;
    if (lat != e.lat || hi !== e.hi || lo !== e.lo) begin
      n_fail++;
      $display("FAIL start_while_busy: got lat=%0d hi=%h lo=%h, want lat=%0d hi=%h lo=%h",
               lat, hi, lo, e.lat, e.hi, e.lo);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL no_queued_start: got busy=%b, want 0", busy);
    end

    // cancel in IDLE suppresses a same-cycle start
    op     = 2'b11;
    src_a  = 32'd9;
    src_b  = 32'd2;
    start  = 1'b1;
    cancel = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    cancel = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL cancel_idle_start: got busy=%b, want 0", busy);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_mthi_with_start;
    int   lat;
    exp_t e;
    mt_write(1'b1, 1'b1, 32'h0BADF00D);
    mthi    = 1'b1;
    wr_data = 32'hDEADBEEF;
    launch(2'b01, 32'd3, 32'd5, {32'd0, 32'd15}, MUL_LAT, 1'b1);
    n_checks++;
    if (hi !== 32'h0BADF00D && busy === 1'b1) begin
      n_fail++; $display("FAIL mthi_dropped: got hi=%h, want 0badf00d", hi);
    end
    wait_done(lat);
    pop_exp(e);
    n_checks++;
    if (lat != e.lat || hi !== e.hi || lo !== e.lo) begin
      n_fail++;
      $display("FAIL start_over_mthi: got lat=%0d hi=%h lo=%h, want lat=%0d hi=%h lo=%h",
               lat, hi, lo, e.lat, e.hi, e.lo);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Back-to-back ops: each starts on the cycle done is observed.
  task automatic test_back_to_back;
    int          lat;
    exp_t        e;
    logic [1:0]  o;
    logic [31:0] a, b;
    @(negedge clk);
    for (int unsigned i = 0; i < 16; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom();
      b = (i % 5 == 4) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom());
      if (i == 1) a = 32'h80000000;
      launch(o, a, b, model(o, a, b), lat_of(o, b), 1'b1);
      wait_done(lat);
      pop_exp(e);
      n_checks++;
      if (lat != e.lat || hi !== e.hi || lo !== e.lo) begin
        n_fail++;
        $display("FAIL b2b_%0d op=%0d a=%h b=%h: got lat=%0d hi=%h lo=%h, want lat=%0d hi=%h lo=%h",
                 i, o, a, b, lat, hi, lo, e.lat, e.hi, e.lo);
      end
    end
    @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_empty: got %0d entries left, want 0", sb_q.size());
    end
  endtask

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    op      = 2'b00;
    src_a   = '0;
    src_b   = '0;
    mthi    = 1'b0;
    mtlo    = 1'b0;
    wr_data = '0;
    cancel  = 1'b0;
    @(negedge clk);
    test_reset();
    test_mthi_mtlo();
    test_multu();
    test_mult();
    test_div();
    test_cancel();
    test_mthi_with_start();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
